// File: rtl/updown_seq_if.sv
// Control and status bundle for updown_seq_counter.
//   master: drives en/load/load_val/load_dir and observes the counter state.
//   slave : the counter; consumes the controls and drives cnt/dir/idx/turn/laps.
interface updown_seq_if #(
    parameter int unsigned W     = 6,
    parameter int unsigned LAP_W = 4
);
    logic             en;
    logic             load;
    logic [W-1:0]     load_val;
    logic             load_dir;
    logic [W-1:0]     cnt;
    logic             dir;
    logic [W:0]       idx;
    logic             turn;
    logic [LAP_W-1:0] laps;

    modport master (
        output en, load, load_val, load_dir,
        input  cnt, dir, idx, turn, laps
    );

    modport slave (
        input  en, load, load_val, load_dir,
        output cnt, dir, idx, turn, laps
    );
endinterface

// File: rtl/updown_seq_counter.sv
// Up/down sequence counter: alternates an upward "swing" sequence (subtract the
// step index when the result stays positive, otherwise add it) up to TOP with a
// downward binary-halving sequence (subtract 2^(n-1)) down to 0.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous reset, active-high
//   bus  - updown_seq_if.slave: en, load, load_val, load_dir in;
//          cnt, dir, idx, turn, laps out (all registered)
module updown_seq_counter #(
    parameter int unsigned W     = 6,
    parameter int unsigned LAP_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    updown_seq_if.slave   bus
);
    // Arithmetic width: two guard bits so cnt+idx and 2^W never truncate.
    localparam int unsigned AW  = W + 2;
    localparam int unsigned IW  = W + 1;
    localparam int unsigned TOP = (1 << W) - 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [W-1:0]     cnt_q,  cnt_d;
    dir_e             dir_q,  dir_d;
    logic [IW-1:0]    idx_q,  idx_d;
    logic             turn_q, turn_d;
    logic [LAP_W-1:0] laps_q, laps_d;

    logic [AW-1:0]    cnt_ext;
    logic [AW-1:0]    idx_ext;
    logic [AW-1:0]    up_r;
    logic [AW-1:0]    down_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            idx_q  <= IW'(1);
            turn_q <= 1'b0;
            laps_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            idx_q  <= idx_d;
            turn_q <= turn_d;
            laps_q <= laps_d;
        end
    end

    // Widened operands and candidate results for both directions.
    always_comb begin
        cnt_ext = AW'(cnt_q);
        idx_ext = AW'(idx_q);
        up_r    = (cnt_ext > idx_ext) ? (cnt_ext - idx_ext) : (cnt_ext + idx_ext);
        // idx is >= 1 in normal operation; d = 2^(idx-1) is at most 2^W.
        down_d  = AW'(1) << (idx_q - IW'(1));
    end

    // Next-state: load > step > hold.
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        idx_d  = idx_q;
        turn_d = 1'b0;
        laps_d = laps_q;

        if (bus.load) begin
            cnt_d = bus.load_val;
            dir_d = dir_e'(bus.load_dir);
            idx_d = IW'(1);
        end else if (bus.en) begin
            if (dir_q == DIR_UP) begin
                if (up_r >= AW'(TOP)) begin
                    // Saturate at TOP and flip downward.
                    cnt_d  = W'(TOP);
                    dir_d  = DIR_DOWN;
                    idx_d  = IW'(1);
                    turn_d = 1'b1;
                end else begin
                    cnt_d = W'(up_r);
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                if (down_d >= cnt_ext) begin
                    // Exact hit or underflow: clamp to 0 and complete a lap.
                    cnt_d  = '0;
                    dir_d  = DIR_UP;
                    idx_d  = IW'(1);
                    turn_d = 1'b1;
                    laps_d = laps_q + LAP_W'(1);
                end else begin
                    cnt_d = W'(cnt_ext - down_d);
                    idx_d = idx_q + IW'(1);
                end
            end
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.dir  = dir_q;
    assign bus.idx  = idx_q;
    assign bus.turn = turn_q;
    assign bus.laps = laps_q;

endmodule

// File: tb/tb_updown_seq_counter.sv
// Directed bench for updown_seq_counter: one W=6/LAP_W=4 instance driven from
// vector tables, one W=4/LAP_W=2 instance driven by hand-written lap sequences.
module tb_updown_seq_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    updown_seq_if #(.W(6), .LAP_W(4)) ifa ();
    updown_seq_if #(.W(4), .LAP_W(2)) ifb ();

    updown_seq_counter #(.W(6), .LAP_W(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    updown_seq_counter #(.W(4), .LAP_W(2)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic  rst;
        logic  en;
        logic  load;
        int    lv;
        logic  ld;
        int    cnt;
        int    dir;
        int    idx;
        int    turn;
        int    laps;
        string name;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    function automatic vec_t mk(string name, logic r, logic e, logic l, int lv, logic ld,
                                int c, int d, int i, int t, int lp);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.load = l; v.lv = lv; v.ld = ld;
        v.cnt = c; v.dir = d; v.idx = i; v.turn = t; v.laps = lp;
        return v;
    endfunction

    task automatic check(string name, int ac, int ad, int ai, int at, int al,
                         int ec, int ed, int ei, int et, int el);
        n_vec++;
        if (ac != ec || ad != ed || ai != ei || at != et || al != el) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d dir=%0d idx=%0d turn=%0d laps=%0d, want cnt=%0d dir=%0d idx=%0d turn=%0d laps=%0d",
                     name, ac, ad, ai, at, al, ec, ed, ei, et, el);
        end
    endtask

    task automatic drive_a(logic r, logic e, logic l, int lv, logic ld);
        @(negedge clk);
        rst_a        = r;
        ifa.en       = e;
        ifa.load     = l;
        ifa.load_val = 6'(lv);
        ifa.load_dir = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(logic r, logic e, logic l, int lv, logic ld);
        @(negedge clk);
        rst_b        = r;
        ifb.en       = e;
        ifb.load     = l;
        ifb.load_val = 4'(lv);
        ifb.load_dir = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(string name, int c, int d, int i, int t, int lp);
        check(name, int'(ifa.cnt), int'(ifa.dir), int'(ifa.idx), int'(ifa.turn), int'(ifa.laps),
              c, d, i, t, lp);
    endtask

    task automatic check_b(string name, int c, int d, int i, int t, int lp);
        check(name, int'(ifb.cnt), int'(ifb.dir), int'(ifb.idx), int'(ifb.turn), int'(ifb.laps),
              c, d, i, t, lp);
    endtask

    task automatic apply_a(vec_t v);
        drive_a(v.rst, v.en, v.load, v.lv, v.ld);
        check_a(v.name, v.cnt, v.dir, v.idx, v.turn, v.laps);
    endtask

    int seq_b [12];

    initial begin
        rst_a = 1'b1; ifa.en = 1'b0; ifa.load = 1'b0; ifa.load_val = '0; ifa.load_dir = 1'b0;
        rst_b = 1'b1; ifb.en = 1'b0; ifb.load = 1'b0; ifb.load_val = '0; ifb.load_dir = 1'b0;

        // W=6 start of the upward run, with a 3-cycle pause at cnt=16.
        tbl1.push_back(mk("a_reset",  1, 0, 0, 0, 0,   0, 0,  1, 0, 0));
        tbl1.push_back(mk("a_up1",    0, 1, 0, 0, 0,   1, 0,  2, 0, 0));
        tbl1.push_back(mk("a_up2",    0, 1, 0, 0, 0,   3, 0,  3, 0, 0));
        tbl1.push_back(mk("a_up3",    0, 1, 0, 0, 0,   6, 0,  4, 0, 0));
        tbl1.push_back(mk("a_up4",    0, 1, 0, 0, 0,   2, 0,  5, 0, 0));
        tbl1.push_back(mk("a_up5",    0, 1, 0, 0, 0,   7, 0,  6, 0, 0));
        tbl1.push_back(mk("a_up6",    0, 1, 0, 0, 0,   1, 0,  7, 0, 0));
        tbl1.push_back(mk("a_up7",    0, 1, 0, 0, 0,   8, 0,  8, 0, 0));
        tbl1.push_back(mk("a_up8",    0, 1, 0, 0, 0,  16, 0,  9, 0, 0));
        tbl1.push_back(mk("a_hold1",  0, 0, 0, 0, 0,  16, 0,  9, 0, 0));
        tbl1.push_back(mk("a_hold2",  0, 0, 0, 0, 0,  16, 0,  9, 0, 0));
        tbl1.push_back(mk("a_hold3",  0, 0, 0, 0, 0,  16, 0,  9, 0, 0));
        tbl1.push_back(mk("a_up9",    0, 1, 0, 0, 0,   7, 0, 10, 0, 0));
        tbl1.push_back(mk("a_up10",   0, 1, 0, 0, 0,  17, 0, 11, 0, 0));

        // W=6 flip at TOP, halving descent, loads and reset corner cases.
        tbl2.push_back(mk("a_up57_top", 0, 1, 0, 0, 0,  63, 1, 1, 1, 0));
        tbl2.push_back(mk("a_dn1",      0, 1, 0, 0, 0,  62, 1, 2, 0, 0));
        tbl2.push_back(mk("a_dn2",      0, 1, 0, 0, 0,  60, 1, 3, 0, 0));
        tbl2.push_back(mk("a_dn3",      0, 1, 0, 0, 0,  56, 1, 4, 0, 0));
        tbl2.push_back(mk("a_dn4",      0, 1, 0, 0, 0,  48, 1, 5, 0, 0));
        tbl2.push_back(mk("a_dn5",      0, 1, 0, 0, 0,  32, 1, 6, 0, 0));
        tbl2.push_back(mk("a_dn6_zero", 0, 1, 0, 0, 0,   0, 0, 1, 1, 1));
        tbl2.push_back(mk("a_lap2_up1", 0, 1, 0, 0, 0,   1, 0, 2, 0, 1));
        tbl2.push_back(mk("a_load5dn",  0, 1, 1, 5, 1,   5, 1, 1, 0, 1));
        tbl2.push_back(mk("a_ld_dn1",   0, 1, 0, 0, 0,   4, 1, 2, 0, 1));
        tbl2.push_back(mk("a_ld_dn2",   0, 1, 0, 0, 0,   2, 1, 3, 0, 1));
        tbl2.push_back(mk("a_ld_clamp", 0, 1, 0, 0, 0,   0, 0, 1, 1, 2));
        tbl2.push_back(mk("a_load0dn",  0, 0, 1, 0, 1,   0, 1, 1, 0, 2));
        tbl2.push_back(mk("a_dn_at0",   0, 1, 0, 0, 0,   0, 0, 1, 1, 3));
        tbl2.push_back(mk("a_up_after", 0, 1, 0, 0, 0,   1, 0, 2, 0, 3));
        tbl2.push_back(mk("a_loadtop",  0, 0, 1, 63, 0, 63, 0, 1, 0, 3));
        tbl2.push_back(mk("a_up_fromtop",0,1, 0, 0, 0,  62, 0, 2, 0, 3));
        tbl2.push_back(mk("a_hold_keep",0, 0, 0, 0, 0,  62, 0, 2, 0, 3));
        tbl2.push_back(mk("a_rst_load", 1, 1, 1, 9, 1,   0, 0, 1, 0, 0));

        foreach (tbl1[i]) apply_a(tbl1[i]);

        // Steps 11..56 of the upward run, then confirm the pre-flip state.
        for (int i = 0; i < 46; i++) drive_a(0, 1, 0, 0, 0);
        check_a("a_up56", 6, 0, 57, 0, 0);

        foreach (tbl2[i]) apply_a(tbl2[i]);

        // W=4 / LAP_W=2: four full laps, laps wraps 1,2,3,0.
        seq_b = '{1, 3, 6, 2, 7, 1, 8, 15, 14, 12, 8, 0};
        drive_b(1, 0, 0, 0, 0);
        check_b("b_reset", 0, 0, 1, 0, 0);
        for (int lap = 1; lap <= 4; lap++) begin
            for (int s = 0; s < 12; s++) begin
                int ed, ei, et, el;
                ed = (s >= 7 && s < 11) ? 1 : 0;
                if (s < 7)       ei = s + 2;
                else if (s == 7) ei = 1;
                else if (s < 11) ei = s - 6;
                else             ei = 1;
                et = (s == 7 || s == 11) ? 1 : 0;
                el = (s == 11) ? (lap % 4) : ((lap - 1) % 4);
                drive_b(0, 1, 0, 0, 0);
                check_b($sformatf("b_lap%0d_s%0d", lap, s + 1), seq_b[s], ed, ei, et, el);
            end
        end

        // Load wins over the step that would saturate at TOP.
        for (int s = 0; s < 7; s++) drive_b(0, 1, 0, 0, 0);
        check_b("b_pre_top", 8, 0, 8, 0, 0);
        drive_b(0, 1, 1, 3, 0);
        check_b("b_load_at_top", 3, 0, 1, 0, 0);
        drive_b(0, 1, 0, 0, 0);
        check_b("b_after_load", 2, 0, 2, 0, 0);
        drive_b(1, 1, 1, 5, 1);
        check_b("b_rst_load", 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
